// File: rtl/paddle_encoder.sv
// Quadrature paddle encoder for one player.
// Synchronises and debounces a raw rotary encoder, decodes committed
// quadrature steps into a saturating paddle position, and hands control to an
// automatic ball-tracking player after a period of encoder inactivity.
module paddle_encoder #(
    parameter int unsigned PADDLE_SIZE  = 5,
    parameter int unsigned DEBOUNCE     = 3,
    parameter int unsigned IDLE_TIMEOUT = 10000,
    parameter int unsigned TRACK_DIV    = 40
) (
    input  logic        game_clk,
    input  logic        reset,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        auto_en,
    input  logic [4:0]  ball_y,
    output logic [31:0] paddle,
    output logic        auto_mode
);

    localparam logic [4:0]  MAX_POS     = 5'(32 - PADDLE_SIZE);
    localparam logic [4:0]  RESET_POS   = 5'((32 - PADDLE_SIZE) / 2);
    localparam logic [31:0] PADDLE_MASK = 32'((64'd1 << PADDLE_SIZE) - 64'd1);
    localparam logic [3:0]  DEB_MAX     = 4'(DEBOUNCE);
    localparam int unsigned IW          = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned TW          = $clog2(TRACK_DIV + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
    localparam logic [TW-1:0] TRK_LAST  = TW'(TRACK_DIV - 1);

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    logic          a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [1:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    deb_q, deb_d;
    logic [4:0]    pos_q, pos_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [TW-1:0] trk_q, trk_d;
    mode_e         mode_q, mode_d;

    logic [1:0]        s2;
    logic              commit;
    logic [1:0]        step;
    logic              fwd, rev, valid;
    logic              wrap;
    logic signed [6:0] tgt_s;
    logic [4:0]        tgt;

    // Position along the quadrature cycle 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] gray_idx(input logic [1:0] s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    // Next-state logic: debounce, decode, idle tracking and auto stepping.
    always_comb begin
        s2 = {a_s2_q, b_s2_q};

        if (s2 == cand_q) begin
            cand_d = cand_q;
            cnt_d  = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 4'd1;
        end else begin
            cand_d = s2;
            cnt_d  = 4'd1;
        end

        // Commit on the edge where the candidate reaches full confidence.
        commit = (cnt_d == DEB_MAX) && (cand_d != deb_q);
        deb_d  = commit ? cand_d : deb_q;

        step  = gray_idx(cand_d) - gray_idx(deb_q);
        fwd   = commit && (step == 2'd1);
        rev   = commit && (step == 2'd3);
        valid = fwd || rev;

        wrap = (mode_q == MODE_AUTO) && (trk_q == TRK_LAST);

        tgt_s = $signed({2'b00, ball_y}) - $signed(7'(PADDLE_SIZE / 2));
        if (tgt_s < 7'sd0)
            tgt = 5'd0;
        else if (tgt_s > $signed({2'b00, MAX_POS}))
            tgt = MAX_POS;
        else
            tgt = tgt_s[4:0];

        // Manual moves take priority over an auto step on the same edge.
        pos_d = pos_q;
        if (fwd) begin
            if (pos_q != MAX_POS) pos_d = pos_q + 5'd1;
        end else if (rev) begin
            if (pos_q != 5'd0) pos_d = pos_q - 5'd1;
        end else if (wrap) begin
            if (pos_q < tgt)      pos_d = pos_q + 5'd1;
            else if (pos_q > tgt) pos_d = pos_q - 5'd1;
        end

        if (valid)
            idle_d = '0;
        else
            idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);

        if (valid)
            mode_d = MODE_MANUAL;
        else
            mode_d = (auto_en && (idle_q == IDLE_MAX)) ? MODE_AUTO : MODE_MANUAL;

        if ((mode_q == MODE_AUTO) && !valid)
            trk_d = wrap ? '0 : trk_q + TW'(1);
        else
            trk_d = '0;
    end

    // State registers, including the two-flop input synchronisers.
    always_ff @(posedge game_clk or negedge reset) begin
        if (!reset) begin
            a_s1_q <= 1'b0;
            a_s2_q <= 1'b0;
            b_s1_q <= 1'b0;
            b_s2_q <= 1'b0;
            cand_q <= '0;
            cnt_q  <= '0;
            deb_q  <= '0;
            pos_q  <= RESET_POS;
            idle_q <= '0;
            trk_q  <= '0;
            mode_q <= MODE_MANUAL;
        end else begin
            a_s1_q <= enc_a;
            a_s2_q <= a_s1_q;
            b_s1_q <= enc_b;
            b_s2_q <= b_s1_q;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            pos_q  <= pos_d;
            idle_q <= idle_d;
            trk_q  <= trk_d;
            mode_q <= mode_d;
        end
    end

    // Bitmap and mode flag decoded from registered state.
    always_comb begin
        paddle    = PADDLE_MASK << pos_q;
        auto_mode = (mode_q == MODE_AUTO);
    end

endmodule
